lfsr_checker: RTL and testbench

Receive-side partner of the 4-bit Fibonacci LFSR pattern generator. The block consumes the generator's output words, self-synchronises a local LFSR to the incoming stream, and reports lock status. Once locked, it counts mismatching words and accepted words for link and datapath BIST. It sits at the sink end of any path driven by the generator.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_sat_counter.sv | 29 ++
 rtl/lfsr_checker.sv | 141 ++++++++++++++
 tb/tb_lfsr_checker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit Fibonacci LFSR generator/checker pair.
// Both ends call lfsr_next so the polynomial is defined in one place.
package lfsr_pkg;

    localparam int         LFSR_WIDTH = 4;
    localparam logic [3:0] LFSR_TAPS  = 4'b1100;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
        input logic [LFSR_WIDTH-1:0] x,
        input logic [LFSR_WIDTH-1:0] taps
    );
        return {x[LFSR_WIDTH-2:0], ^(x & taps)};
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module lfsr_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count register: holds at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the incoming pattern,
// reports lock, and counts mismatches and accepted words while locked.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                    WIDTH    = LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] TAPS     = LFSR_TAPS,
    parameter int                    SYNC_CNT = 3,
    parameter int                    LOSS_CNT = 4,
    parameter int                    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);

    localparam int MATCH_W = $clog2(SYNC_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    lfsr_state_e        r_state,     w_state_nxt;
    logic [WIDTH-1:0]   r_expected,  w_expected_nxt;
    logic [MATCH_W-1:0] r_match_cnt, w_match_cnt_nxt;
    logic [MISS_W-1:0]  r_miss_cnt,  w_miss_cnt_nxt;
    logic               r_locked;
    logic               r_err,       w_err_nxt;
    logic               w_err_inc;
    logic               w_word_inc;
    logic               w_is_zero;
    logic               w_is_match;

    assign w_is_zero  = (in_data == {WIDTH{1'b0}});
    assign w_is_match = (in_data == r_expected);

    // State/register update for the synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_expected  <= {WIDTH{1'b0}};
            r_match_cnt <= {MATCH_W{1'b0}};
            r_miss_cnt  <= {MISS_W{1'b0}};
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err       <= w_err_nxt;
        end
    end

    // Next-state and counting decisions; idle cycles hold everything
    always_comb begin
        w_state_nxt     = r_state;
        w_expected_nxt  = r_expected;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_err_nxt       = 1'b0;
        w_err_inc       = 1'b0;
        w_word_inc      = 1'b0;
        if (in_valid) begin
            case (r_state)
                HUNT: begin
                    if (!w_is_zero) begin
                        w_expected_nxt  = lfsr_next(in_data, TAPS);
                        w_match_cnt_nxt = {MATCH_W{1'b0}};
                        w_state_nxt     = SYNC;
                    end else begin
                        w_state_nxt     = HUNT;
                    end
                end
                SYNC: begin
                    if (w_is_match) begin
                        w_expected_nxt = lfsr_next(in_data, TAPS);
                        if (r_match_cnt == MATCH_W'(SYNC_CNT - 1)) begin
                            w_state_nxt     = LOCKED;
                            w_match_cnt_nxt = {MATCH_W{1'b0}};
                            w_miss_cnt_nxt  = {MISS_W{1'b0}};
                        end else begin
                            w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
                        end
                    end else if (!w_is_zero) begin
                        w_expected_nxt  = lfsr_next(in_data, TAPS);
                        w_match_cnt_nxt = {MATCH_W{1'b0}};
                    end else begin
                        w_state_nxt     = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-run the local LFSR so one bad word costs one error
                    w_expected_nxt = lfsr_next(r_expected, TAPS);
                    w_word_inc     = 1'b1;
                    if (w_is_match) begin
                        w_miss_cnt_nxt = {MISS_W{1'b0}};
                    end else begin
                        w_err_nxt = 1'b1;
                        w_err_inc = 1'b1;
                        if (r_miss_cnt == MISS_W'(LOSS_CNT - 1)) begin
                            w_state_nxt    = HUNT;
                            w_miss_cnt_nxt = {MISS_W{1'b0}};
                        end else begin
                            w_miss_cnt_nxt = r_miss_cnt + MISS_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_err_inc),
        .i_clear (clear),
        .o_count (err_count)
    );

    lfsr_sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .i_inc   (w_word_inc),
        .i_clear (clear),
        .o_count (word_count)
    );

    assign locked = r_locked;
    assign err    = r_err;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: directed words with hand-computed
// expected outputs queued by the driver and checked by an independent monitor.
module tb_lfsr_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clear;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [15:0] word_count;

    int checks   = 0;
    int failures = 0;
    int vec_id   = 0;

    typedef struct {
        int   id;
        logic l;
        logic e;
        int   ec;
        int   wc;
    } exp_t;

    exp_t exp_q[$];

    lfsr_checker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clear      (clear),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string nm, input int id, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s vec%0d got=%b want=%b", nm, id, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int id, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s vec%0d got=%0d want=%0d", nm, id, got, want);
        end
    endtask

    // Drive one cycle of input and queue the outputs expected after its edge
    task automatic step(input logic v, input logic [3:0] d, input logic c,
                        input logic el, input logic ee, input int eec, input int ewc);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clear    = c;
        x.id = vec_id; x.l = el; x.e = ee; x.ec = eec; x.wc = ewc;
        exp_q.push_back(x);
        vec_id++;
    endtask

    // Monitor: one expectation per sampled edge, compared just after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check_bit("locked", x.id, locked, x.l);
                check_bit("err", x.id, err, x.e);
                check_int("err_count", x.id, int'(err_count), x.ec);
                check_int("word_count", x.id, int'(word_count), x.wc);
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 4'b0000; clear = 1'b0;
        #12;
        check_bit("rst_locked", -1, locked, 1'b0);
        check_bit("rst_err", -1, err, 1'b0);
        check_int("rst_err_count", -1, int'(err_count), 0);
        check_int("rst_word_count", -1, int'(word_count), 0);
        @(negedge clk);
        rst = 1'b1;

        // Lock from seed 0001, 16 gapless words
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 0, 1);
        step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 0, 2);
        step(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 0, 3);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 0, 4);
        step(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 0, 5);
        step(1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 0, 6);
        step(1'b1, 4'b0111, 1'b0, 1'b1, 1'b0, 0, 7);
        step(1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 0, 8);
        step(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 0, 9);
        step(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 0, 10);
        step(1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 0, 11);
        step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 12);

        // Single corrupted word (0000 in place of 1101)
        step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 0, 13);
        step(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 0, 14);
        step(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 0, 15);
        step(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 0, 16);
        step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0, 0, 17);
        step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1, 18);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 19);
        step(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1, 20);

        // Four consecutive bad words drop lock on the fourth
        step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 2, 21);
        step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 3, 22);
        step(1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 4, 23);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 5, 24);
        // Resume the true stream: relock after four words
        step(1'b1, 4'b1100, 1'b0, 1'b0, 1'b0, 5, 24);
        step(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 5, 24);
        step(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 5, 24);
        step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 5, 24);
        step(1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 5, 25);
        step(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 5, 25);
        step(1'b1, 4'b1001, 1'b0, 1'b1, 1'b0, 5, 26);
        step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 5, 26);
        step(1'b1, 4'b0011, 1'b0, 1'b1, 1'b0, 5, 27);

        // clear coincident with an error: err fires, counters read 0
        step(1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 0);
        step(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 0, 1);

        // Lose lock with zero words, then hunt through zeros
        step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 1, 2);
        step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 2, 3);
        step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1, 3, 4);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 4, 5);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        // Reacquire with alternating gaps: lock after the 4th valid word
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 5);
        step(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 4, 5);
        step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4, 5);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 4, 6);
        step(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 4, 6);
        step(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 4, 7);
        step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4, 7);

        // Mid-stream asynchronous reset, away from any clock edge
        @(posedge clk);
        #3;
        check_int("drain_queue", -2, exp_q.size(), 0);
        rst = 1'b0;
        #1;
        check_bit("arst_locked", -3, locked, 1'b0);
        check_bit("arst_err", -3, err, 1'b0);
        check_int("arst_err_count", -3, int'(err_count), 0);
        check_int("arst_word_count", -3, int'(word_count), 0);
        @(negedge clk);
        rst = 1'b1;

        // Resynchronise from the first valid nonzero word
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 4'b1101, 1'b0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 0, 1);
        step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 1);

        repeat (3) @(posedge clk);
        #3;
        check_int("final_queue", -4, exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
